// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel arbiter: FSM state encoding,
// command register bit positions and a channel-index helper.
package dma_pkg;

  localparam int NCH_DEF = 4;
  localparam int CH_W    = 2;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } arb_state_t;

  // Channel that follows ch in the rotation ring (wraps 3 -> 0).
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return CH_W'(ch + 1'b1);
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Rotating priority encoder: first set bit of pending, scanning upward from
// topCh and wrapping modulo 4.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [3:0]      pending,
  input  logic [CH_W-1:0] topCh,
  output logic [CH_W-1:0] winner,
  output logic            any
);

  logic [CH_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx    = '0;
    winner = topCh;
    any    = |pending;
    for (int i = 3; i >= 0; i--) begin
      idx = CH_W'(topCh + CH_W'(i));
      if (pending[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel arbiter: merges DREQ with mask/request registers, runs
// the HRQ/HLDA handshake and holds one channel's DACK until end of service.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NCH-1:0]  dreq,
  input  logic [7:0]      commandReg,
  input  logic [3:0]      maskReg,
  input  logic [3:0]      requestReg,
  input  logic            hlda,
  input  logic            svcDone,
  output logic            hrq,
  output logic [NCH-1:0]  dack,
  output logic            grantValid,
  output logic [CH_W-1:0] grantCh,
  output logic [CH_W-1:0] topCh
);

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] grant_ch_q, grant_ch_d;
  logic [CH_W-1:0] top_ch_q, top_ch_d;

  logic [3:0]      pending;
  logic            ctl_off;
  logic            rotate;
  logic [CH_W-1:0] scan_top;
  logic [CH_W-1:0] winner;
  logic            pend_any;
  logic [NCH-1:0]  dack_int;
  logic            unused_cmd;

  assign ctl_off  = commandReg[CMD_DISABLE];
  assign rotate   = commandReg[CMD_ROTATE];

  // Software requests bypass the mask; hardware requests are polarity-corrected first.
  assign pending  = ((dreq ^ {NCH{commandReg[CMD_DREQ_LOW]}}) & ~maskReg) | requestReg;
  assign scan_top = rotate ? top_ch_q : '0;

  assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  dma_prio_encoder u_prio_enc (
    .pending (pending),
    .topCh   (scan_top),
    .winner  (winner),
    .any     (pend_any)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      grant_ch_q <= '0;
      top_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      top_ch_q   <= top_ch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    top_ch_d   = rotate ? top_ch_q : '0;
    hrq        = 1'b0;
    grantValid = 1'b0;
    dack_int   = '0;

    case (state_q)
      IDLE: begin
        if (!ctl_off && pend_any) begin
          state_d = REQ;
        end
      end

      REQ: begin
        hrq = 1'b1;
        if (hlda && pend_any) begin
          grant_ch_d = winner;
          state_d    = GRANT;
        end else if (!pend_any || ctl_off) begin
          state_d = RELEASE;
        end
      end

      // Ownership is sticky: only end of service or loss of HLDA ends it.
      GRANT: begin
        hrq                  = 1'b1;
        grantValid           = 1'b1;
        dack_int[grant_ch_q] = 1'b1;
        if (svcDone) begin
          if (rotate) begin
            top_ch_d = next_ch(grant_ch_q);
          end
          state_d = RELEASE;
        end else if (!hlda) begin
          state_d = RELEASE;
        end
      end

      // Wait for the CPU to take the bus back before any new request.
      RELEASE: begin
        if (!hlda) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dack    = dack_int ^ {NCH{~commandReg[CMD_DACK_HIGH]}};
  assign grantCh = grant_ch_q;
  assign topCh   = top_ch_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: a bus-ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] dreq = 4'h0;
  logic [7:0] commandReg = 8'h00;
  logic [3:0] maskReg = 4'h0;
  logic [3:0] requestReg = 4'h0;
  logic       hlda = 1'b0;
  logic       svcDone = 1'b0;
  logic       hrq;
  logic [3:0] dack;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [1:0] topCh;

  int checks = 0;
  int errors = 0;
  bit follow = 1'b0;

  // Model of bus ownership: requesting, owner (-1 = none), waiting for hlda low.
  bit m_req = 1'b0;
  int m_owner = -1;
  bit m_wait_low = 1'b0;
  int m_top = 0;
  int m_last = 0;

  dma_priority_arbiter #(.NCH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .dreq       (dreq),
    .commandReg (commandReg),
    .maskReg    (maskReg),
    .requestReg (requestReg),
    .hlda       (hlda),
    .svcDone    (svcDone),
    .hrq        (hrq),
    .dack       (dack),
    .grantValid (grantValid),
    .grantCh    (grantCh),
    .topCh      (topCh)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int start);
    for (int k = 0; k < 4; k++) begin
      if (p[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge CLK) begin : model
    logic [3:0] pend;
    int st;
    int nt;
    pend = ((dreq ^ {4{commandReg[6]}}) & ~maskReg) | requestReg;
    st   = commandReg[4] ? m_top : 0;
    nt   = st;
    if (!RESET) begin
      m_req      <= 1'b0;
      m_owner    <= -1;
      m_wait_low <= 1'b0;
      m_top      <= 0;
      m_last     <= 0;
    end else begin
      if (m_owner >= 0) begin
        if (svcDone) begin
          if (commandReg[4]) nt = (m_owner + 1) % 4;
          m_owner <= -1; m_req <= 1'b0; m_wait_low <= 1'b1;
        end else if (!hlda) begin
          m_owner <= -1; m_req <= 1'b0; m_wait_low <= 1'b1;
        end
      end else if (m_wait_low) begin
        if (!hlda) m_wait_low <= 1'b0;
      end else if (m_req) begin
        if (hlda && pend != 4'h0) begin
          m_owner <= pick(pend, st);
          m_last  <= pick(pend, st);
        end else if (pend == 4'h0 || commandReg[2]) begin
          m_req <= 1'b0; m_wait_low <= 1'b1;
        end
      end else if (!commandReg[2] && pend != 4'h0) begin
        m_req <= 1'b1;
      end
      m_top <= nt;
    end
  end

  always @(posedge CLK) begin : compare
    logic [3:0] ed;
    #1;
    ed = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    if (!commandReg[7]) ed = ~ed;
    check("model_hrq", hrq, m_req);
    check("model_grantValid", grantValid, (m_owner >= 0));
    check("model_grantCh", grantCh, m_last);
    check("model_topCh", topCh, m_top);
    check("model_dack", dack, ed);
  end

  always @(negedge CLK) begin
    if (follow) hlda = hrq;
  end

  task automatic wait_hrq(input int max);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (hrq !== 1'b1 && n < max);
    check("hrq_wait", hrq, 1);
  endtask

  task automatic wait_grant(input int max);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (grantValid !== 1'b1 && n < max);
    check("grant_wait", grantValid, 1);
  endtask

  task automatic settle();
    follow     = 1'b0;
    hlda       = 1'b0;
    svcDone    = 1'b0;
    requestReg = 4'h0;
    dreq       = commandReg[6] ? 4'hF : 4'h0;
    repeat (4) @(negedge CLK);
    check("settle_idle", {hrq, grantValid}, 0);
  endtask

  initial begin
    int exp_g[5];
    int exp_t[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_t = '{1, 2, 3, 0, 1};

    repeat (2) @(negedge CLK);
    check("rst_hrq", hrq, 0);
    check("rst_grantValid", grantValid, 0);
    check("rst_grantCh", grantCh, 0);
    check("rst_topCh", topCh, 0);
    check("rst_dack", dack, 4'hF);
    RESET = 1'b1;
    @(negedge CLK);

    // Fixed priority, ch1 and ch3 requesting
    commandReg = 8'h00; maskReg = 4'h0; dreq = 4'b1010;
    wait_hrq(10);
    repeat (2) @(negedge CLK);
    hlda = 1'b1;
    wait_grant(10);
    check("fixed_grantCh", grantCh, 1);
    check("fixed_dack", dack, 4'b1101);
    check("fixed_topCh", topCh, 0);
    svcDone = 1'b1; dreq = 4'h0;
    @(negedge CLK);
    svcDone = 1'b0;
    check("fixed_rel_hrq", hrq, 0);
    check("fixed_rel_gv", grantValid, 0);
    check("fixed_rel_dack", dack, 4'hF);
    check("fixed_rel_topCh", topCh, 0);
    settle();

    // Rotating priority, all channels requesting
    commandReg = 8'h10; dreq = 4'hF; follow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(20);
      check("rot_grantCh", grantCh, exp_g[i]);
      svcDone = 1'b1;
      @(negedge CLK);
      svcDone = 1'b0;
      check("rot_topCh", topCh, exp_t[i]);
    end
    follow = 1'b0; hlda = 1'b0; dreq = 4'h0; commandReg = 8'h00;
    @(negedge CLK);
    check("fixed_mode_top_reset", topCh, 0);
    settle();

    // Masked hardware request, unmasked software request
    maskReg = 4'b0001; dreq = 4'b0001; requestReg = 4'b0100; follow = 1'b1;
    wait_grant(20);
    check("sw_grantCh", grantCh, 2);
    check("sw_dack", dack, 4'b1011);
    svcDone = 1'b1; requestReg = 4'h0;
    @(negedge CLK);
    svcDone = 1'b0;
    settle();
    dreq = 4'b0001; follow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("masked_no_hrq", hrq, 0);
    end
    maskReg = 4'h0;
    settle();

    // Active-low DREQ, active-high DACK
    commandReg = 8'hC0; dreq = 4'hF;
    @(negedge CLK);
    check("pol_idle_dack", dack, 4'h0);
    dreq = 4'b1110; follow = 1'b1;
    wait_grant(20);
    check("pol_grantCh", grantCh, 0);
    check("pol_dack", dack, 4'b0001);
    svcDone = 1'b1; dreq = 4'hF;
    @(negedge CLK);
    svcDone = 1'b0;
    check("pol_rel_dack", dack, 4'h0);
    settle();
    commandReg = 8'h00;
    settle();

    // Controller disabled while requesting
    dreq = 4'b0100;
    wait_hrq(10);
    commandReg = 8'h04;
    @(negedge CLK);
    check("dis_hrq", hrq, 0);
    check("dis_gv", grantValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("dis_no_grant", {hrq, grantValid}, 0);
    end
    commandReg = 8'h00;
    settle();

    // Abort by hlda loss leaves topCh alone
    commandReg = 8'h10; dreq = 4'b0010; follow = 1'b1;
    wait_grant(20);
    check("abort_pre_grantCh", grantCh, 1);
    svcDone = 1'b1; dreq = 4'h0;
    @(negedge CLK);
    svcDone = 1'b0;
    check("abort_pre_topCh", topCh, 2);
    settle();
    dreq = 4'b1000;
    wait_hrq(10);
    hlda = 1'b1;
    wait_grant(10);
    check("abort_grantCh", grantCh, 3);
    hlda = 1'b0; dreq = 4'h0;
    @(negedge CLK);
    check("abort_gv", grantValid, 0);
    check("abort_hrq", hrq, 0);
    check("abort_dack", dack, 4'hF);
    check("abort_topCh", topCh, 2);
    settle();

    // Reset in the middle of a grant
    dreq = 4'b0100;
    wait_hrq(10);
    hlda = 1'b1;
    wait_grant(10);
    check("midrst_pre_grantCh", grantCh, 2);
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_hrq", hrq, 0);
    check("midrst_gv", grantValid, 0);
    check("midrst_topCh", topCh, 0);
    check("midrst_dack", dack, 4'hF);
    check("midrst_grantCh", grantCh, 0);
    RESET = 1'b1; hlda = 1'b0; dreq = 4'h0;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel arbiter and bus-request sequencer for the 8237A-compatible DMA controller. It merges the four hardware DREQ lines with the software request and mask registers, requests the bus from the CPU (HRQ/HLDA), and selects one channel using fixed or rotating priority. It then asserts that channel's DACK and holds the grant until the transfer timing engine reports end of service. It sits between the register file (command, mask and request registers) and the transfer timing state machine.

## Interface
Parameters:
- NCH, 4, number of DMA channels; the design is only required to support 4.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- dreq  in  NCH  raw DMA request pins; polarity is set by commandReg[6].
- commandReg  in  8  command register. Bit 2 = controller disable, bit 4 = rotating priority, bit 6 = DREQ active-low, bit 7 = DACK active-high.
- maskReg  in  4  per-channel mask; 1 blocks hardware DREQ.
- requestReg  in  4  software requests; not masked.
- hlda  in  1  hold acknowledge from the CPU.
- svcDone  in  1  one-cycle pulse from the timing engine: current channel service complete.
- hrq  out  1  hold request to the CPU.
- dack  out  NCH  DMA acknowledge pins, with polarity applied from commandReg[7].
- grantValid  out  1  a channel currently owns the bus.
- grantCh  out  2  index of the granted channel; valid when grantValid=1.
- topCh  out  2  current highest-priority channel.

## Operation
- pending = ((dreq XOR {4{commandReg[6]}}) AND NOT maskReg) OR requestReg, evaluated every cycle.
- Winner selection:
  - Scan from topCh upward, modulo 4, and take the first set bit of pending.
  - In fixed mode (commandReg[4]=0), topCh is forced to 0.
- FSM states, from the shared package: IDLE, REQ, GRANT, RELEASE.
- IDLE:
  - hrq=0.
  - If commandReg[2]=0 and pending≠0, go to REQ.
- REQ:
  - hrq=1.
  - If hlda=1 and pending≠0: latch the winner into grantCh and go to GRANT.
  - If pending=0 or commandReg[2]=1: go to RELEASE.
- GRANT:
  - hrq=1, grantValid=1, and the internal dack bit for grantCh is 1.
  - The grant is held regardless of later pending changes or commandReg[2].
  - On svcDone:
    - In rotating mode, set topCh = grantCh+1 (mod 4).
    - Go to RELEASE.
  - If hlda falls without svcDone: abort, go to RELEASE, topCh unchanged.
- RELEASE:
  - hrq=0, grantValid=0, dack inactive.
  - Return to IDLE when hlda=0.
- svcDone outside GRANT is ignored.
- Output polarity: dack = dackInt XOR {4{~commandReg[7]}}. All inactive is 4'hF when commandReg[7]=0 and 4'h0 when commandReg[7]=1.
- Switching commandReg[4] from 1 to 0 resets topCh to 0 on the next cycle.

## Timing
- Reset (RESET=0 at an edge):
  - State returns to IDLE; hrq=0, grantValid=0, grantCh=0, topCh=0, dackInt=0.
  - Reset applied mid-GRANT drops hrq and dack on that same edge.
- DREQ to HRQ: pending seen in cycle N gives hrq=1 from cycle N+1.
- HLDA to DACK: hlda=1 sampled at edge M gives dack and grantValid asserted from M+1.
- svcDone to release: svcDone sampled at edge K deasserts dack, grantValid and hrq from K+1. The topCh update is also visible from K+1.
- Minimum gap between two grants is 2 cycles: RELEASE to IDLE to REQ. A new HRQ is not raised before hlda has been seen low.
- Simultaneous hardware and software requests on one channel count as a single request.
- If hlda is already high while in IDLE, it is ignored until REQ.

## Structure
- Shared package dma_pkg holds:
  - the FSM state enum `arb_state_t`;
  - command bit index constants: CMD_DISABLE=2, CMD_ROTATE=4, CMD_DREQ_LOW=6, CMD_DACK_HIGH=7.
- One combinational sub-module, dma_prio_encoder: inputs pending[3:0] and topCh[1:0]; outputs winner[1:0] and any.
- The FSM, the topCh register and the polarity logic live in dma_priority_arbiter.

## Test plan
- Fixed priority, commandReg=8'h00, maskReg=0, dreq=4'b1010, hlda raised 2 cycles after hrq -> grantCh=1, dack=4'b1101. After svcDone, hrq=0 next cycle and topCh stays 0.
- Rotating priority, commandReg=8'h10, dreq=4'b1111 held, hlda tied to hrq -> grant sequence 0,1,2,3,0; topCh after each service is 1,2,3,0,1.
- Mask plus software request: maskReg=4'b0001, dreq=4'b0001, requestReg=4'b0100 -> grantCh=2. With requestReg=0 -> hrq never asserts.
- Polarity: commandReg=8'hC0, dreq=4'b1110 (ch0 active-low) -> grantCh=0, dack=4'b0001. Idle dack=4'h0.
- Disable and abort:
  - commandReg[2]=1 set while in REQ -> hrq drops next cycle and no grant is issued.
  - hlda dropped mid-GRANT -> dack inactive next cycle and topCh unchanged.
- Reset mid-GRANT: RESET=0 for 1 cycle -> hrq=0, grantValid=0, topCh=0, dack=4'hF on that edge.
